// File: rtl/sprite_draw_engine.sv
// Sprite rasteriser for the 160x120 VGA adapter: on each plot strobe it erases the
// sprite at its previous position, then draws it at the new one, one pixel per clk.
module sprite_draw_engine #(
  parameter int unsigned SPRITE_SIZE  = 4,
  parameter int unsigned H_RES        = 160,
  parameter int unsigned V_RES        = 120,
  parameter logic [2:0]  BG_COLOUR    = 3'b000,
  parameter logic [2:0]  PAC_COLOUR   = 3'b110,
  parameter logic [2:0]  GHOST_COLOUR = 3'b100,
  parameter logic [2:0]  ALT_COLOUR   = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       plot,
  input  logic [1:0] s_plot_color,
  input  logic [7:0] x_position,
  input  logic [6:0] y_position,
  input  logic       forget_old,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam int unsigned CW = 3;
  localparam int unsigned PW = 3;
  localparam logic [PW-1:0] LAST = PW'(SPRITE_SIZE - 1);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

  state_t         state;
  logic [XW-1:0]  new_x;
  logic [XW-1:0]  old_x;
  logic [YW-1:0]  new_y;
  logic [YW-1:0]  old_y;
  logic [CW-1:0]  colour;
  logic           old_valid;
  logic [PW-1:0]  col;
  logic [PW-1:0]  row;
  logic [PW-1:0]  col_nxt;
  logic [PW-1:0]  row_nxt;
  logic           last_px;

  // col/row hold the pixel currently on the outputs; these point at the one after it
  assign last_px = (col == LAST) && (row == LAST);
  assign col_nxt = (col == LAST) ? '0 : col + PW'(1);
  assign row_nxt = (col == LAST) ? row + PW'(1) : row;

  // {in_frame, x, y} for a sprite pixel; sums are one bit wider so nothing wraps
  function automatic logic [XW+YW:0] pixel(input logic [XW-1:0] bx,
                                           input logic [YW-1:0] by,
                                           input logic [PW-1:0] c,
                                           input logic [PW-1:0] r);
    logic [XW:0] px;
    logic [YW:0] py;
    px = (XW+1)'(bx) + (XW+1)'(c);
    py = (YW+1)'(by) + (YW+1)'(r);
    return {(px < (XW+1)'(H_RES)) && (py < (YW+1)'(V_RES)), px[XW-1:0], py[YW-1:0]};
  endfunction

  function automatic logic [CW-1:0] decode(input logic [1:0] sel);
    case (sel)
      2'd0:    return BG_COLOUR;
      2'd1:    return PAC_COLOUR;
      2'd2:    return GHOST_COLOUR;
      default: return ALT_COLOUR;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      new_x      <= '0;
      new_y      <= '0;
      old_x      <= '0;
      old_y      <= '0;
      colour     <= '0;
      old_valid  <= 1'b0;
      col        <= '0;
      row        <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          vga_plot <= 1'b0;
          busy     <= 1'b0;
          if (forget_old) old_valid <= 1'b0;
          if (plot) begin
            new_x  <= x_position;
            new_y  <= y_position;
            colour <= decode(s_plot_color);
            col    <= '0;
            row    <= '0;
            busy   <= 1'b1;
            // forget_old in the same cycle suppresses the erase
            if (old_valid && !forget_old) begin
              state                     <= ERASE;
              {vga_plot, vga_x, vga_y}  <= pixel(old_x, old_y, '0, '0);
              vga_colour                <= BG_COLOUR;
            end else begin
              state                     <= DRAW;
              {vga_plot, vga_x, vga_y}  <= pixel(x_position, y_position, '0, '0);
              vga_colour                <= decode(s_plot_color);
            end
          end
        end
        ERASE: begin
          if (last_px) begin
            state                    <= DRAW;
            col                      <= '0;
            row                      <= '0;
            {vga_plot, vga_x, vga_y} <= pixel(new_x, new_y, '0, '0);
            vga_colour               <= colour;
          end else begin
            col                      <= col_nxt;
            row                      <= row_nxt;
            {vga_plot, vga_x, vga_y} <= pixel(old_x, old_y, col_nxt, row_nxt);
            vga_colour               <= BG_COLOUR;
          end
        end
        DRAW: begin
          if (last_px) begin
            state     <= DONE;
            vga_plot  <= 1'b0;
            done      <= 1'b1;
            old_x     <= new_x;
            old_y     <= new_y;
            old_valid <= 1'b1;
          end else begin
            col                      <= col_nxt;
            row                      <= row_nxt;
            {vga_plot, vga_x, vga_y} <= pixel(new_x, new_y, col_nxt, row_nxt);
            vga_colour               <= colour;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
